// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          PC_STEP      = 4;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction buffer: synchronous FIFO with flush taking priority over push.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int CW = cnt_width(DEPTH),
    localparam int AW = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, issues word-aligned imem reads and queues
// in-order responses for decode; redirects flush queued and in-flight fetches.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter int                  QUEUE_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(RESET_PC_DEF)
)(
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [PC_WIDTH-1:0]    instr_pc
);

    localparam int                  CW         = cnt_width(QUEUE_DEPTH);
    localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(PC_STEP);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(3);
    localparam logic [CW:0]         DEPTH_LIM  = (CW+1)'(QUEUE_DEPTH);

    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] head_pc;
    logic [PC_WIDTH-1:0] redirect_target;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       discard;
    logic [CW-1:0]       count;
    logic [CW:0]         inflight;
    logic                req_fire;
    logic                rsp_ok;
    logic                keep_rsp;
    logic                pop;

    // Every slot is reserved at request time, so the queue can never overflow.
    assign inflight        = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid  = !rst && !redirect_valid && (inflight < DEPTH_LIM);
    assign imem_addr       = fetch_pc;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign redirect_target = redirect_pc & ~ALIGN_MASK;

    // A response with nothing outstanding is spurious and ignored entirely.
    assign rsp_ok   = imem_rsp_valid && (outstanding != '0);
    assign keep_rsp = rsp_ok && (discard == '0) && !redirect_valid;

    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready;
    assign instr_pc    = head_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            head_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc    <= redirect_target;
            head_pc     <= redirect_target;
            outstanding <= outstanding - CW'(rsp_ok);
            discard     <= outstanding - CW'(rsp_ok);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + STEP;
            if (pop)      head_pc  <= head_pc + STEP;
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_ok);
            if (rsp_ok && (discard != '0)) discard <= discard - CW'(1);
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (INSTR_WIDTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (keep_rsp),
        .push_data (imem_rsp_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head_data (instr_data)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order latency memory model plus a stream-level
// reference (expected head PC / next request address) checked every cycle.
module tb_fetch_unit;

    localparam logic [31:0] MAGIC = 32'hA5A5_0000;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat     = 1;
    int rr_mode = 0;
    int last_due = 0;
    logic [3:0] rr_pat = 4'b1001;   // ready pattern 1,0,0,1 by cycle

    logic [31:0] pend_addr[$];
    int          pend_due[$];

    // Reference: next PC decode should see and next address memory should be asked for.
    logic [31:0] exp_pc, exp_addr;
    logic [31:0] e_pc, e_data, e_addr;
    logic        o_req_v, o_iv, o_acc, o_pop, o_rsp;
    logic [31:0] o_addr, o_idata, o_ipc;

    // One clock cycle: drive memory side, sample DUT, advance model, move to next negedge.
    task automatic tick();
        int due;
        case (rr_mode)
            0:       imem_req_ready = 1'b1;
            1:       imem_req_ready = rr_pat[cyc % 4];
            default: imem_req_ready = ($urandom_range(0, 9) < 7);
        endcase
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
        end
        o_rsp = 1'b0;
        if (!rst && pend_due.size() > 0 && pend_due[0] == cyc) begin
            o_rsp          = 1'b1;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend_addr[0] ^ MAGIC;
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        o_req_v = imem_req_valid;
        o_addr  = imem_addr;
        o_iv    = instr_valid;
        o_idata = instr_data;
        o_ipc   = instr_pc;
        o_acc   = o_req_v && imem_req_ready;
        o_pop   = o_iv && instr_ready;
        e_pc    = exp_pc;
        e_data  = exp_pc ^ MAGIC;
        e_addr  = exp_addr;
        if (o_acc) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_addr.push_back(o_addr);
            pend_due.push_back(due);
            exp_addr = exp_addr + 32'd4;
        end
        if (o_pop) exp_pc = exp_pc + 32'd4;
        if (rst) begin
            exp_pc   = RPC;
            exp_addr = RPC;
        end else if (redirect_valid) begin
            exp_pc   = {redirect_pc[31:2], 2'b00};
            exp_addr = {redirect_pc[31:2], 2'b00};
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        rr_mode = 0;
        tick();
        n_tests++; if (o_req_v !== 1'b0) begin n_fail++; $display("FAIL reset_req_during_rst got %b want 0", o_req_v); end
        tick();
        n_tests++; if (o_iv !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid got %b want 0", o_iv); end
        n_tests++; if (o_idata !== 32'h0) begin n_fail++; $display("FAIL reset_instr_data got %h want 0", o_idata); end
        n_tests++; if (o_ipc !== RPC) begin n_fail++; $display("FAIL reset_instr_pc got %h want %h", o_ipc, RPC); end
        n_tests++; if (o_req_v !== 1'b0) begin n_fail++; $display("FAIL reset_req_held got %b want 0", o_req_v); end
        rst = 1'b0;
        tick();
        n_tests++; if (o_req_v !== 1'b1 || o_addr !== RPC) begin n_fail++; $display("FAIL reset_first_req got v=%b a=%h want v=1 a=%h", o_req_v, o_addr, RPC); end
    endtask

    task automatic test_stream();
        int first = 0;
        int nv = 0;
        lat = 1; rr_mode = 0;
        do_reset();
        instr_ready = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (o_iv) begin nv++; if (first == 0) first = t; end
            n_tests++; if (o_ipc !== e_pc) begin n_fail++; $display("FAIL stream_pc t=%0d got %h want %h", t, o_ipc, e_pc); end
            if (o_iv) begin n_tests++; if (o_idata !== e_data) begin n_fail++; $display("FAIL stream_data t=%0d got %h want %h", t, o_idata, e_data); end end
            if (o_acc) begin n_tests++; if (o_addr !== e_addr) begin n_fail++; $display("FAIL stream_addr t=%0d got %h want %h", t, o_addr, e_addr); end end
        end
        n_tests++; if (first != 3) begin n_fail++; $display("FAIL stream_first_valid got cycle %0d want 3", first); end
        n_tests++; if (nv != 18) begin n_fail++; $display("FAIL stream_throughput got %0d want 18", nv); end
    endtask

    task automatic test_stall();
        int nacc = 0;
        int pops = 0;
        lat = 1; rr_mode = 0;
        do_reset();
        instr_ready = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (o_acc) begin
                n_tests++; if (o_addr !== 32'(nacc * 4)) begin n_fail++; $display("FAIL stall_addr got %h want %h", o_addr, 32'(nacc * 4)); end
                nacc++;
            end
            n_tests++; if (o_ipc !== RPC) begin n_fail++; $display("FAIL stall_pc_held t=%0d got %h want %h", t, o_ipc, RPC); end
        end
        n_tests++; if (nacc != 4) begin n_fail++; $display("FAIL stall_req_count got %0d want 4", nacc); end
        n_tests++; if (o_req_v !== 1'b0) begin n_fail++; $display("FAIL stall_req_low got %b want 0", o_req_v); end
        n_tests++; if (o_iv !== 1'b1 || o_idata !== MAGIC) begin n_fail++; $display("FAIL stall_head got v=%b d=%h want v=1 d=%h", o_iv, o_idata, MAGIC); end
        instr_ready = 1'b1;
        for (int i = 0; i < 20 && pops < 4; i++) begin
            tick();
            if (o_pop) begin
                n_tests++; if (o_ipc !== 32'(pops * 4) || o_idata !== (32'(pops * 4) ^ MAGIC)) begin
                    n_fail++; $display("FAIL stall_release got pc=%h d=%h want pc=%h", o_ipc, o_idata, 32'(pops * 4));
                end
                pops++;
            end
        end
        n_tests++; if (pops != 4) begin n_fail++; $display("FAIL stall_release_count got %0d want 4", pops); end
    endtask

    task automatic test_req_ready_toggle();
        int pops = 0;
        lat = 2; rr_mode = 1;
        do_reset();
        instr_ready = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (o_pop) pops++;
            n_tests++; if (o_ipc !== e_pc) begin n_fail++; $display("FAIL toggle_pc t=%0d got %h want %h", t, o_ipc, e_pc); end
            if (o_iv) begin n_tests++; if (o_idata !== e_data) begin n_fail++; $display("FAIL toggle_data t=%0d got %h want %h", t, o_idata, e_data); end end
            if (o_acc) begin n_tests++; if (o_addr !== e_addr) begin n_fail++; $display("FAIL toggle_addr t=%0d got %h want %h", t, o_addr, e_addr); end end
        end
        n_tests++; if (pops < 12) begin n_fail++; $display("FAIL toggle_progress got %0d want >=12", pops); end
        rr_mode = 0;
    endtask

    task automatic test_redirect_inflight();
        int first = 0;
        int nacc = 0;
        lat = 3; rr_mode = 0;
        do_reset();
        instr_ready = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            redirect_valid = (t == 4);
            redirect_pc = 32'h0000_0103;
            if (t == 4) begin
                n_tests++; if (nacc != 3) begin n_fail++; $display("FAIL redir_outstanding got %0d want 3", nacc); end
            end
            tick();
            if (o_acc) nacc++;
            n_tests++; if (o_ipc !== e_pc) begin n_fail++; $display("FAIL redir_pc t=%0d got %h want %h", t, o_ipc, e_pc); end
            if (o_iv) begin n_tests++; if (o_idata !== e_data) begin n_fail++; $display("FAIL redir_data t=%0d got %h want %h", t, o_idata, e_data); end end
            if (t > 4 && o_iv && first == 0) begin
                first = t;
                n_tests++; if (o_ipc !== 32'h100) begin n_fail++; $display("FAIL redir_first_pc got %h want 00000100", o_ipc); end
            end else if (first != 0 && t == first + 1) begin
                n_tests++; if (o_iv !== 1'b1 || o_ipc !== 32'h104) begin n_fail++; $display("FAIL redir_second got v=%b pc=%h want 1/00000104", o_iv, o_ipc); end
            end
        end
        redirect_valid = 1'b0;
        n_tests++; if (first != 9) begin n_fail++; $display("FAIL redir_latency got cycle %0d want 9", first); end
    endtask

    task automatic test_redirect_pop_rsp();
        int first = 0;
        logic [31:0] tgt;
        lat = 1; rr_mode = 0;
        tgt = $urandom;
        tgt[1:0] = 2'b00;
        do_reset();
        instr_ready = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            redirect_valid = (t == 6);
            redirect_pc = tgt | 32'h1;
            tick();
            if (t == 6) begin
                n_tests++; if (!(o_pop && o_rsp) || o_ipc !== 32'd12) begin
                    n_fail++; $display("FAIL redir_same_cycle got pop=%b rsp=%b pc=%h want 1/1/0000000c", o_pop, o_rsp, o_ipc);
                end
            end
            n_tests++; if (o_ipc !== e_pc) begin n_fail++; $display("FAIL redir2_pc t=%0d got %h want %h", t, o_ipc, e_pc); end
            if (o_iv) begin n_tests++; if (o_idata !== e_data) begin n_fail++; $display("FAIL redir2_data t=%0d got %h want %h", t, o_idata, e_data); end end
            if (t > 6 && o_iv && first == 0) begin
                first = t;
                n_tests++; if (o_ipc !== tgt) begin n_fail++; $display("FAIL redir2_first_pc got %h want %h", o_ipc, tgt); end
            end
        end
        redirect_valid = 1'b0;
        n_tests++; if (first != 9) begin n_fail++; $display("FAIL redir2_latency got cycle %0d want 9", first); end
    endtask

    task automatic test_wrap_and_rst();
        logic [31:0] addrs[$];
        lat = 1; rr_mode = 0;
        do_reset();
        instr_ready = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            redirect_valid = (t == 2);
            redirect_pc = 32'hFFFF_FFFE;
            tick();
            if (t > 2 && o_acc) addrs.push_back(o_addr);
            n_tests++; if (o_ipc !== e_pc) begin n_fail++; $display("FAIL wrap_pc t=%0d got %h want %h", t, o_ipc, e_pc); end
            if (o_iv) begin n_tests++; if (o_idata !== e_data) begin n_fail++; $display("FAIL wrap_data t=%0d got %h want %h", t, o_idata, e_data); end end
        end
        redirect_valid = 1'b0;
        n_tests++; if (addrs.size() < 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0) begin
            n_fail++; $display("FAIL wrap_addr got n=%0d a0=%h a1=%h want fffffffc,00000000", addrs.size(),
                                addrs.size() > 0 ? addrs[0] : 32'hx, addrs.size() > 1 ? addrs[1] : 32'hx);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_tests++; if (o_iv !== 1'b0 || o_ipc !== RPC) begin n_fail++; $display("FAIL midrst_state got v=%b pc=%h want 0/%h", o_iv, o_ipc, RPC); end
        n_tests++; if (o_req_v !== 1'b1 || o_addr !== RPC) begin n_fail++; $display("FAIL midrst_req got v=%b a=%h want 1/%h", o_req_v, o_addr, RPC); end
    endtask

    task automatic test_random();
        int pops = 0;
        logic hold = 1'b0;
        logic [31:0] h_pc = '0, h_data = '0;
        lat = 2; rr_mode = 2;
        do_reset();
        for (int t = 1; t <= 800; t++) begin
            if (t % 100 == 0) lat = $urandom_range(1, 3);
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc = $urandom;
            rst = ($urandom_range(0, 199) == 0);
            tick();
            if (o_pop) pops++;
            n_tests++; if (o_ipc !== e_pc) begin n_fail++; $display("FAIL rand_pc t=%0d got %h want %h", t, o_ipc, e_pc); end
            if (o_iv) begin n_tests++; if (o_idata !== e_data) begin n_fail++; $display("FAIL rand_data t=%0d got %h want %h", t, o_idata, e_data); end end
            if (o_acc) begin n_tests++; if (o_addr !== e_addr) begin n_fail++; $display("FAIL rand_addr t=%0d got %h want %h", t, o_addr, e_addr); end end
            if (rst || redirect_valid) begin n_tests++; if (o_req_v !== 1'b0) begin n_fail++; $display("FAIL rand_req_blocked t=%0d got %b want 0", t, o_req_v); end end
            if (hold) begin
                n_tests++; if (o_iv !== 1'b1 || o_ipc !== h_pc || o_idata !== h_data) begin
                    n_fail++; $display("FAIL rand_stable t=%0d got v=%b pc=%h d=%h want 1/%h/%h", t, o_iv, o_ipc, o_idata, h_pc, h_data);
                end
            end
            hold = o_iv && !instr_ready && !rst && !redirect_valid;
            h_pc = o_ipc;
            h_data = o_idata;
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
        n_tests++; if (pops < 100) begin n_fail++; $display("FAIL rand_progress got %0d want >=100", pops); end
    endtask

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        exp_pc = RPC;
        exp_addr = RPC;
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_req_ready_toggle();
        test_redirect_inflight();
        test_redirect_pop_rsp();
        test_wrap_and_rst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage upstream of decode: owns the fetch PC, issues word-aligned reads to instruction memory over a ready/valid request channel, and buffers in-order responses in a small queue. Delivers instruction/PC pairs to decode over a valid/ready handshake. Replaces the combinational PCreg/PCInc/InstrMem path so that memory with latency of one or more cycles and stalls are tolerated. Branch/jump targets arrive on a redirect port that flushes queued and in-flight fetches.

## Interface
- PC_WIDTH, 32, fetch/redirect PC width
- INSTR_WIDTH, 32, instruction word width
- QUEUE_DEPTH, 4, instruction queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  PC_WIDTH  request address, bits[1:0] always 0
- imem_rsp_valid  in  1  response valid (in order, ≥1 cycle after accept)
- imem_rsp_data  in  INSTR_WIDTH  response instruction
- redirect_valid  in  1  load new fetch PC, flush
- redirect_pc  in  PC_WIDTH  target; bits[1:0] ignored (forced 0)
- instr_valid  out  1  queue head valid
- instr_ready  in  1  decode accepts head
- instr_data  out  INSTR_WIDTH  head instruction
- instr_pc  out  PC_WIDTH  PC of head instruction

## Operation
- Registers: fetch_pc, head_pc, outstanding (0..QUEUE_DEPTH), discard (0..QUEUE_DEPTH), queue with count.
- Reset: fetch_pc=head_pc=RESET_PC, outstanding=discard=0, queue empty; outputs imem_req_valid=0 during rst, instr_valid=0, instr_data=0, instr_pc=RESET_PC.
- Request: imem_req_valid = !rst && !redirect_valid && (outstanding + count < QUEUE_DEPTH). imem_addr = fetch_pc. On accept: fetch_pc += 4 (wraps mod 2^PC_WIDTH), outstanding++.
- Response: outstanding-- on every imem_rsp_valid. If discard>0: drop data, discard--. Else push into queue.
- Pop: instr_valid && instr_ready → dequeue, head_pc += 4. instr_pc = head_pc.
- Redirect (highest priority): fetch_pc = head_pc = {redirect_pc[PC_WIDTH-1:2],2'b00}; queue emptied; discard = outstanding minus 1 if a response arrives this cycle; any response this cycle is dropped. A pop in the same cycle completes (consumed instruction retired), then flush applies.
- Simultaneous request accept + response: outstanding unchanged.
- Response with outstanding==0: illegal, ignored (assertion in bench).
- No combinational path from imem_rsp_* to instr_*; from redirect_valid only to imem_req_valid.

## Timing
- Reset released at edge E0: first request valid in cycle after E0.
- Latency: request accept at cycle n, response at n+L → instr_valid at n+L+1.
- Sustained 1 instr/cycle requires QUEUE_DEPTH ≥ L+2 with instr_ready held high; default covers L≤2.
- First post-redirect instr_valid: earliest 2+L cycles after redirect cycle (req next cycle).
- Redirect or rst mid-burst: all stale responses dropped; no stale instruction ever appears on instr_*.
- instr_data/instr_pc stable while instr_valid && !instr_ready.

## Structure
- Package fetch_pkg: RESET_PC default, PC_STEP=4, counter width function/localparam $clog2(QUEUE_DEPTH+1).
- Sub-module fetch_queue: synchronous FIFO (push, pop, flush, count, head data), pointers wrap mod QUEUE_DEPTH, flush priority over push.
- Top fetch_unit holds PC, counters and handshake logic.

## Test plan
- Reset, L=1 memory returning addr^32'hA5A5_0000, instr_ready=1 → instr_pc 0,4,8,12… one per cycle from 3rd cycle, data matches.
- instr_ready=0 for 10 cycles → exactly 4 requests issued (0x0–0xC), then imem_req_valid low; instr_pc held 0x0; release → 0x0,0x4,0x8,0xC in order.
- imem_req_ready toggling 1,0,0,1 with L=2 → no address skipped or repeated; instr sequence contiguous.
- Redirect to 0x103 with 3 requests outstanding, L=3 → 3 responses dropped, next instr_pc=0x100, then 0x104.
- Redirect in same cycle as a response and a pop → popped instr consumed, response dropped, next instr_pc=redirect target.
- fetch_pc=0xFFFF_FFFC via redirect → following request addr 0x0000_0000; rst asserted mid-stream → next cycle instr_valid=0, instr_pc=RESET_PC.
